// File: rtl/audio_system_pio_leds.sv
// -----------------------------------------------------------------------------
// audio_system_pio_leds
//
// Avalon-MM slave output port for the board LEDs. Software writes the DATA
// register directly or through atomic OUTSET / OUTCLEAR aliases. A free-running
// blink engine toggles a phase bit every BLINK_PERIOD+1 cycles. While the phase
// is 1, every bit selected by BLINK_MASK is forced off.
//
// Register map (word addresses):
//   0 DATA          RW  WIDTH bits
//   1 BLINK_MASK    RW  WIDTH bits
//   2 BLINK_PERIOD  RW  PERIOD_WIDTH bits
//   3 STATUS        RO  bit0 = blink phase, bit1 = blink active (period != 0)
//   4 OUTSET        WO  DATA |=  writedata
//   5 OUTCLEAR      WO  DATA &= ~writedata
//   6,7 reserved    writes ignored, reads 0
//
// Ports:
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   address    register word select
//   chipselect slave selected
//   write_n    active-low write strobe
//   writedata  write data (only low WIDTH / PERIOD_WIDTH bits used)
//   readdata   registered read data, updated every cycle from address
//   out_port   registered LED drive
// -----------------------------------------------------------------------------
module audio_system_pio_leds #(
   parameter int unsigned             WIDTH        = 10,
   parameter logic [WIDTH-1:0]        RESET_VALUE  = '0,
   parameter int unsigned             PERIOD_WIDTH = 24
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [2:0]                 address,
   input  logic                       chipselect,
   input  logic                       write_n,
   input  logic [31:0]                writedata,
   output logic [31:0]                readdata,
   output logic [WIDTH-1:0]           out_port
);

   typedef enum logic [2:0] {
      ADDR_DATA     = 3'd0,
      ADDR_MASK     = 3'd1,
      ADDR_PERIOD   = 3'd2,
      ADDR_STATUS   = 3'd3,
      ADDR_OUTSET   = 3'd4,
      ADDR_OUTCLEAR = 3'd5,
      ADDR_RSVD6    = 3'd6,
      ADDR_RSVD7    = 3'd7
   } reg_addr_e;

   reg_addr_e               addr;
   logic                    wr;
   logic [WIDTH-1:0]        wd_bits;
   logic [PERIOD_WIDTH-1:0] wd_period;

   logic [WIDTH-1:0]        data_reg;
   logic [WIDTH-1:0]        mask_reg;
   logic [PERIOD_WIDTH-1:0] period_reg;
   logic [PERIOD_WIDTH-1:0] counter;
   logic                    phase;
   logic [31:0]             rd_next;

   // Upper writedata bits are architecturally ignored.
   logic                    unused_wd;

   assign addr      = reg_addr_e'(address);
   assign wr        = chipselect & ~write_n;
   assign wd_bits   = writedata[WIDTH-1:0];
   assign wd_period = writedata[PERIOD_WIDTH-1:0];
   assign unused_wd = ^writedata;

   // ---------------------------------------------------------------------------
   // DATA register, including the read-modify-write set/clear aliases
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         data_reg <= RESET_VALUE;
      end else if (wr) begin
         case (addr)
            ADDR_DATA:     data_reg <= wd_bits;
            ADDR_OUTSET:   data_reg <= data_reg | wd_bits;
            ADDR_OUTCLEAR: data_reg <= data_reg & ~wd_bits;
            default:       data_reg <= data_reg;
         endcase
      end
   end

   // ---------------------------------------------------------------------------
   // BLINK_MASK and BLINK_PERIOD
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         mask_reg   <= '0;
         period_reg <= '0;
      end else if (wr) begin
         if (addr == ADDR_MASK) begin
            mask_reg <= wd_bits;
         end
         if (addr == ADDR_PERIOD) begin
            period_reg <= wd_period;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Blink engine. A period write restarts the engine on the same edge, which
   // also keeps the counter from ever running past a newly shrunk period.
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         counter <= '0;
         phase   <= 1'b0;
      end else if (wr && (addr == ADDR_PERIOD)) begin
         counter <= '0;
         phase   <= 1'b0;
      end else if (period_reg == '0) begin
         counter <= '0;
         phase   <= 1'b0;
      end else if (counter == period_reg) begin
         counter <= '0;
         phase   <= ~phase;
      end else begin
         counter <= counter + PERIOD_WIDTH'(1);
      end
   end

   // ---------------------------------------------------------------------------
   // Read mux: independent of chipselect, unused bits zero
   // ---------------------------------------------------------------------------
   always_comb begin
      rd_next = '0;
      case (addr)
         ADDR_DATA:   rd_next[WIDTH-1:0]        = data_reg;
         ADDR_MASK:   rd_next[WIDTH-1:0]        = mask_reg;
         ADDR_PERIOD: rd_next[PERIOD_WIDTH-1:0] = period_reg;
         ADDR_STATUS: rd_next[1:0]              = {(period_reg != '0), phase};
         default:     rd_next                   = '0;
      endcase
   end

   // ---------------------------------------------------------------------------
   // Registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         readdata <= '0;
         out_port <= RESET_VALUE;
      end else begin
         readdata <= rd_next;
         out_port <= data_reg & ~(mask_reg & {WIDTH{phase}});
      end
   end

endmodule

// File: tb/tb_audio_system_pio_leds.sv
// -----------------------------------------------------------------------------
// Testbench for audio_system_pio_leds. A reference model tracks the register
// file and derives the blink phase from the number of cycles elapsed since the
// engine was last restarted; every cycle readdata and out_port are compared.
// -----------------------------------------------------------------------------
module tb_audio_system_pio_leds;

   localparam int unsigned W  = 10;
   localparam int unsigned PW = 24;
   localparam logic [W-1:0] RV = '0;

   logic          clk = 1'b0;
   logic          reset;
   logic [2:0]    address;
   logic          chipselect;
   logic          write_n;
   logic [31:0]   writedata;
   logic [31:0]   readdata;
   logic [W-1:0]  out_port;

   int unsigned   n_tests = 0;
   int unsigned   n_fail  = 0;

   // reference model state
   logic [W-1:0]  m_data  = RV;
   logic [W-1:0]  m_mask  = '0;
   longint        m_per   = 0;
   longint        m_el    = 0;
   logic          m_phase = 1'b0;
   logic [31:0]   exp_rd  = '0;
   logic [W-1:0]  exp_out = RV;

   audio_system_pio_leds #(
      .WIDTH        (W),
      .RESET_VALUE  (RV),
      .PERIOD_WIDTH (PW)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .address    (address),
      .chipselect (chipselect),
      .write_n    (write_n),
      .writedata  (writedata),
      .readdata   (readdata),
      .out_port   (out_port)
   );

   always #5 clk = ~clk;

   // Model: phase is floor(elapsed / (P+1)) mod 2 since the last restart.
   always @(posedge clk) begin
      if (reset) begin
         exp_rd  = '0;
         exp_out = RV;
         m_data  = RV;
         m_mask  = '0;
         m_per   = 0;
         m_el    = 0;
      end else begin
         exp_out = m_phase ? (m_data & ~m_mask) : m_data;
         case (address)
            3'd0:    exp_rd = 32'(m_data);
            3'd1:    exp_rd = 32'(m_mask);
            3'd2:    exp_rd = 32'(m_per);
            3'd3:    exp_rd = {30'd0, (m_per != 0), m_phase};
            default: exp_rd = 32'd0;
         endcase
         m_el = m_el + 1;
         if (chipselect && !write_n) begin
            case (address)
               3'd0: m_data = writedata[W-1:0];
               3'd1: m_mask = writedata[W-1:0];
               3'd2: begin
                  m_per = longint'(writedata[PW-1:0]);
                  m_el  = 0;
               end
               3'd4: m_data = m_data | writedata[W-1:0];
               3'd5: m_data = m_data & ~writedata[W-1:0];
               default: ;
            endcase
         end
      end
      m_phase = (m_per == 0) ? 1'b0 : (((m_el / (m_per + 1)) % 2) == 1);
   end

   task automatic check_value(input string tag, input logic [31:0] got,
                              input logic [31:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, want, $time);
      end
   endtask

   // One bus cycle: drive, clock, then compare against the model on negedge.
   task automatic cyc(input logic rst, input logic cs, input logic wn,
                      input logic [2:0] a, input logic [31:0] wd);
      reset      = rst;
      chipselect = cs;
      write_n    = wn;
      address    = a;
      writedata  = wd;
      @(posedge clk);
      @(negedge clk);
      check_value("model_out", 32'(out_port), 32'(exp_out));
      check_value("model_rd", readdata, exp_rd);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] wd);
      cyc(1'b0, 1'b1, 1'b0, a, wd);
   endtask

   task automatic rd(input logic [2:0] a);
      cyc(1'b0, 1'b0, 1'b1, a, 32'd0);
   endtask

   initial begin
      logic [31:0] wd;
      logic [2:0]  a;

      // reset
      cyc(1'b1, 1'b0, 1'b1, 3'd0, 32'd0);
      cyc(1'b1, 1'b0, 1'b1, 3'd0, 32'd0);
      check_value("reset_out", 32'(out_port), 32'd0);
      check_value("reset_rd", readdata, 32'd0);
      for (int i = 0; i < 4; i++) begin
         rd(3'(i));
         check_value("reset_reg_rd", readdata, 32'd0);
      end

      // DATA write, upper bits dropped
      wr(3'd0, 32'hFFFF_F2A5);
      rd(3'd0);
      check_value("data_rb", readdata, 32'h2A5);
      check_value("data_out", 32'(out_port), 32'h2A5);

      // set / clear back to back
      wr(3'd4, 32'h00F);
      wr(3'd5, 32'h200);
      rd(3'd0);
      check_value("setclr_rb", readdata, 32'h0AF);
      rd(3'd4);
      check_value("outset_rd0", readdata, 32'd0);

      // blink: period 3, each phase 4 cycles
      wr(3'd0, 32'h3FF);
      wr(3'd1, 32'h003);
      wr(3'd2, 32'd3);
      for (int j = 1; j <= 14; j++) begin
         rd(3'd3);
         check_value("blink_out", 32'(out_port),
                     (((j - 1) / 4) % 2 == 1) ? 32'h3FC : 32'h3FF);
         check_value("blink_status", readdata,
                     (((j - 1) / 4) % 2 == 1) ? 32'd3 : 32'd2);
      end

      // period rewrite while phase=1, counter=2
      wr(3'd2, 32'd1);
      for (int k = 1; k <= 8; k++) begin
         rd(3'd3);
         check_value("p1_out", 32'(out_port),
                     (((k - 1) / 2) % 2 == 1) ? 32'h3FC : 32'h3FF);
      end
      wr(3'd2, 32'd0);
      for (int k = 1; k <= 4; k++) begin
         rd(3'd3);
         check_value("idle_out", 32'(out_port), 32'h3FF);
      end
      check_value("idle_status", readdata, 32'd0);

      // reset during phase 1, coincident with a DATA write
      wr(3'd2, 32'd3);
      for (int k = 1; k <= 5; k++) rd(3'd3);
      check_value("pre_rst_out", 32'(out_port), 32'h3FC);
      cyc(1'b1, 1'b1, 1'b0, 3'd0, 32'h155);
      check_value("rst_out", 32'(out_port), 32'(RV));
      rd(3'd1);
      check_value("rst_mask", readdata, 32'd0);
      rd(3'd2);
      check_value("rst_period", readdata, 32'd0);
      rd(3'd0);
      check_value("rst_data", readdata, 32'(RV));

      // randomized traffic
      for (int n = 0; n < 3000; n++) begin
         a  = 3'($urandom_range(0, 7));
         wd = (a == 3'd2) ? $urandom_range(0, 6) : $urandom;
         cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0),
             ($urandom_range(0, 1) == 1), a, wd);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
